// File: rtl/video_pkg.sv
// Shared constants and FSM encoding for the video write queue.
// Region field selects register space (queued) versus bulk memory (forwarded).
package video_pkg;

    localparam logic [3:0] REGION_REG    = 4'h0;
    localparam logic [3:0] REGION_TEX    = 4'h1;
    localparam logic [3:0] REGION_TILE   = 4'h2;
    localparam logic [3:0] REGION_SPRITE = 4'h3;

    localparam int REGION_MSB = 23;
    localparam int REGION_LSB = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wq_state_e;

endpackage

// File: rtl/video_wq_fifo.sv
// Synchronous FIFO holding {wstrb, addr, wdata} register writes.
// The head word is combinational so a pop can be registered by the caller in the same edge.
module video_wq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 68
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push while full is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/video_write_queue.sv
// CPU write path into the video block: register writes wait for vblank, memory writes pass through.
// Optional status outputs wq_level/wq_overflow are built only with VIDEO_WQ_STATUS_EN defined.
module video_write_queue
    import video_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iomem_valid,
    input  logic [3:0]               iomem_wstrb,
    input  logic [ADDR_W-1:0]        iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic                     iomem_ready,
    input  logic                     vblank,
    output logic                     vid_valid,
    output logic [3:0]               vid_wstrb,
    output logic [ADDR_W-1:0]        vid_addr,
    output logic [31:0]              vid_wdata
`ifdef VIDEO_WQ_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]   wq_level,
    output logic                     wq_overflow
`endif
);
    localparam int ENTRY_W = 4 + ADDR_W + 32;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    wq_state_e state_q, state_d;

    logic               vblank_q, iomem_ready_q;
    logic               vid_valid_q;
    logic [3:0]         vid_wstrb_q;
    logic [ADDR_W-1:0]  vid_addr_q;
    logic [31:0]        vid_wdata_q;

    logic [3:0]         region;
    logic               req, has_strb, is_reg, fwd, pop, push, accept;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level;

    assign region   = iomem_addr[REGION_MSB:REGION_LSB];
    assign is_reg   = (region == REGION_REG);
    assign has_strb = |iomem_wstrb;
    assign req      = iomem_valid && !iomem_ready_q;

    // A forward owns vid_* next cycle, so the drain pop yields to it.
    assign fwd    = req && has_strb && !is_reg;
    assign pop    = (state_q == DRAIN) && !fifo_empty && !fwd;
    assign push   = req && has_strb && is_reg && (!fifo_full || pop);
    assign accept = req && (!has_strb || !is_reg || !fifo_full || pop);

    video_wq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({iomem_wstrb, iomem_addr, iomem_wdata}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vblank && !vblank_q && !fifo_empty) state_d = DRAIN;
            DRAIN:   if (!vblank || fifo_level == '0)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vblank_q      <= 1'b0;
            iomem_ready_q <= 1'b0;
            vid_valid_q   <= 1'b0;
            vid_wstrb_q   <= '0;
            vid_addr_q    <= '0;
            vid_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            vblank_q      <= vblank;
            iomem_ready_q <= accept;
            if (fwd) begin
                vid_valid_q <= 1'b1;
                vid_wstrb_q <= iomem_wstrb;
                vid_addr_q  <= iomem_addr;
                vid_wdata_q <= iomem_wdata;
            end else if (pop) begin
                vid_valid_q <= 1'b1;
                {vid_wstrb_q, vid_addr_q, vid_wdata_q} <= head;
            end else begin
                vid_valid_q <= 1'b0;
                vid_wstrb_q <= '0;
            end
        end
    end

    assign iomem_ready = iomem_ready_q;
    assign vid_valid   = vid_valid_q;
    assign vid_wstrb   = vid_wstrb_q;
    assign vid_addr    = vid_addr_q;
    assign vid_wdata   = vid_wdata_q;

`ifdef VIDEO_WQ_STATUS_EN
    logic wq_overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wq_overflow_q <= 1'b0;
        end else if (req && has_strb && is_reg && fifo_full && !pop) begin
            wq_overflow_q <= 1'b1;
        end
    end

    assign wq_level    = fifo_level;
    assign wq_overflow = wq_overflow_q;
`endif

endmodule

// File: tb/tb_video_write_queue.sv
// Scoreboard bench for video_write_queue: register writes expected in acceptance order,
// memory writes expected one cycle after acceptance; status ports checked when VIDEO_WQ_STATUS_EN is set.
module tb_video_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic        vblank;
    logic        vid_valid;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_addr;
    logic [31:0] vid_wdata;
`ifdef VIDEO_WQ_STATUS_EN
    logic [4:0]  wq_level;
    logic        wq_overflow;
`endif

    video_write_queue #(.DEPTH(16), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .vblank      (vblank),
        .vid_valid   (vid_valid),
        .vid_wstrb   (vid_wstrb),
        .vid_addr    (vid_addr),
        .vid_wdata   (vid_wdata)
`ifdef VIDEO_WQ_STATUS_EN
        ,
        .wq_level    (wq_level),
        .wq_overflow (wq_overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vid_pulses = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int model_level = 0;
    bit ready_prev = 1'b0;
    bit done17 = 1'b0;
    bit rand_done = 1'b0;
    logic [67:0] q_reg[$];
    logic [67:0] q_mem[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented write is matched against the expectation queues.
    always @(negedge clk) begin
        logic [67:0] got;
        logic [67:0] exp;
        if (vid_valid) begin
            got = {vid_wstrb, vid_addr, vid_wdata};
            vid_pulses++;
            if (vid_pulses == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (vid_addr[23:20] == 4'h0) begin
                if (q_reg.size() == 0) begin
                    chk("reg_unexpected", got, 68'h0);
                end else begin
                    exp = q_reg.pop_front();
                    chk("reg_order", got, exp);
                    model_level--;
                end
            end else begin
                if (q_mem.size() == 0) begin
                    chk("fwd_unexpected", got, 68'h0);
                end else begin
                    exp = q_mem.pop_front();
                    chk("fwd_data", got, exp);
                    chk("fwd_timing", 68'(iomem_ready), 68'h1);
                end
            end
        end else begin
            chk("idle_wstrb", 68'(vid_wstrb), 68'h0);
        end
        chk("ready_width", 68'(iomem_ready && ready_prev), 68'h0);
        ready_prev = iomem_ready;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        q_reg.delete();
        q_mem.delete();
        model_level = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int budget);
        int n;
        n = 0;
        if (strb != 4'h0) begin
            if (addr[23:20] == 4'h0) q_reg.push_back({strb, addr, data});
            else                     q_mem.push_back({strb, addr, data});
        end
        iomem_addr  = addr;
        iomem_wdata = data;
        iomem_wstrb = strb;
        iomem_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < budget);
        if (!iomem_ready) begin
            checks++;
            errors++;
            $display("FAIL cpu_write_timeout actual=no_ack required=ack addr=%h", addr);
        end else if (strb != 4'h0 && addr[23:20] == 4'h0) begin
            model_level++;
        end
        iomem_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q_reg.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 68'(q_reg.size()), 68'h0);
    endtask

    initial begin
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        vblank      = 1'b1;

        // vblank already high at reset release must not start a drain
        do_reset();
        chk("rst_ready", 68'(iomem_ready), 68'h0);
        chk("rst_vid", {vid_valid, vid_wstrb, vid_addr, vid_wdata}, 68'h0);
`ifdef VIDEO_WQ_STATUS_EN
        chk("rst_level", 68'(wq_level), 68'h0);
        chk("rst_ovf", 68'(wq_overflow), 68'h0);
`endif
        vid_pulses = 0;
        cpu_write(32'h0500_0100, 32'h11, 4'hF, 20);
        cpu_write(32'h0500_0104, 32'h22, 4'hF, 20);
        wait_cycles(6);
        chk("vblank_at_release", 68'(vid_pulses), 68'h0);
        vblank = 1'b0;
        do_reset();

        // three queued register writes, delivered on the vblank edge
        vid_pulses = 0;
        cpu_write(32'h0500_0000, 32'h1, 4'hF, 20);
        cpu_write(32'h0500_0004, 32'h2, 4'hF, 20);
        cpu_write(32'h0500_0008, 32'h3, 4'hF, 20);
        wait_cycles(4);
        chk("q3_held", 68'(vid_pulses), 68'h0);
`ifdef VIDEO_WQ_STATUS_EN
        chk("q3_level", 68'(wq_level), 68'd3);
`endif
        vblank = 1'b1;
        wait_cycles(8);
        chk("q3_count", 68'(vid_pulses), 68'd3);
        chk("q3_consecutive", 68'(last_cyc - first_cyc), 68'd2);
        vblank = 1'b0;
        wait_cycles(2);

        // memory-region write forwarded immediately; zero-strobe writes are silent
        vid_pulses = 0;
        cpu_write(32'h0520_0010, 32'h2A, 4'hF, 20);
        cpu_write(32'h0500_0040, 32'h77, 4'h0, 20);
        cpu_write(32'h0530_0040, 32'h78, 4'h0, 20);
        wait_cycles(3);
        chk("fwd_count", 68'(vid_pulses), 68'd1);
`ifdef VIDEO_WQ_STATUS_EN
        chk("fwd_level", 68'(wq_level), 68'd0);
`endif

        // fill, then stall on the 17th until the first drain pop
        vid_pulses = 0;
        for (int i = 0; i < 16; i++)
            cpu_write(32'h0500_0000 + 32'(4*i), 32'(100 + i), 4'hF, 20);
        done17 = 1'b0;
        fork
            begin
                cpu_write(32'h0500_0200, 32'hABCD, 4'h3, 300);
                done17 = 1'b1;
            end
            begin
                wait_cycles(6);
                chk("full_stall", {66'h0, done17, iomem_ready}, 68'h0);
`ifdef VIDEO_WQ_STATUS_EN
                chk("full_level", 68'(wq_level), 68'd16);
                chk("full_ovf", 68'(wq_overflow), 68'h1);
`endif
                vblank = 1'b1;
            end
        join
        wait_drain(100);
        wait_cycles(2);
        chk("full_count", 68'(vid_pulses), 68'd17);
`ifdef VIDEO_WQ_STATUS_EN
        chk("ovf_sticky", 68'(wq_overflow), 68'h1);
`endif
        vblank = 1'b0;
        wait_cycles(2);

        // forward lands mid-drain and takes its own slot
        vid_pulses = 0;
        for (int i = 0; i < 4; i++)
            cpu_write(32'h0500_0300 + 32'(4*i), 32'(200 + i), 4'hF, 20);
        vblank = 1'b1;
        @(posedge clk);
        wait_cycles(1);
        cpu_write(32'h0510_0800, 32'hBEEF, 4'hC, 20);
        wait_cycles(8);
        chk("mid_count", 68'(vid_pulses), 68'd5);
        chk("mid_consecutive", 68'(last_cyc - first_cyc), 68'd4);
        vblank = 1'b0;
        wait_cycles(2);

        // short vblank: three entries now, the rest on the next edge
        vid_pulses = 0;
        for (int i = 0; i < 8; i++)
            cpu_write(32'h0500_0400 + 32'(4*i), 32'(300 + i), 4'hF, 20);
        vblank = 1'b1;
        wait_cycles(3);
        vblank = 1'b0;
        wait_cycles(4);
        chk("short_count", 68'(vid_pulses), 68'd3);
        chk("short_remaining", 68'(q_reg.size()), 68'd5);
`ifdef VIDEO_WQ_STATUS_EN
        chk("short_level", 68'(wq_level), 68'(model_level));
`endif
        vblank = 1'b1;
        wait_drain(40);
        wait_cycles(2);
        chk("short_total", 68'(vid_pulses), 68'd8);
        vblank = 1'b0;
        wait_cycles(2);

        // reset in the middle of a drain discards the queue
        for (int i = 0; i < 6; i++)
            cpu_write(32'h0500_0500 + 32'(4*i), 32'(400 + i), 4'hF, 20);
        vblank = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q_reg.delete();
        model_level = 0;
        chk("drain_rst_vid", {vid_valid, vid_wstrb, vid_addr, vid_wdata}, 68'h0);
        chk("drain_rst_ready", 68'(iomem_ready), 68'h0);
`ifdef VIDEO_WQ_STATUS_EN
        chk("drain_rst_level", 68'(wq_level), 68'h0);
        chk("drain_rst_ovf", 68'(wq_overflow), 68'h0);
`endif
        reset  = 1'b0;
        vblank = 1'b0;
        wait_cycles(3);
        vid_pulses = 0;
        vblank = 1'b1;
        wait_cycles(8);
        chk("drain_rst_empty", 68'(vid_pulses), 68'h0);
        vblank = 1'b0;
        wait_cycles(2);

        // randomized traffic against free-running vblank
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    logic [31:0] a;
                    logic [3:0]  s;
                    a = {8'h05, 4'(0), 18'($urandom), 2'b00};
                    if ($urandom_range(0, 9) < 4) a[23:20] = 4'($urandom_range(1, 3));
                    s = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    cpu_write(a, $urandom, s, 200);
                    if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 4));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    vblank = 1'b1;
                    wait_cycles($urandom_range(4, 20));
                    vblank = 1'b0;
                    wait_cycles($urandom_range(2, 15));
                end
            end
        join
        vblank = 1'b0;
        wait_cycles(2);
        vblank = 1'b1;
        wait_drain(100);
        wait_cycles(2);
        chk("rand_fwd_done", 68'(q_mem.size()), 68'h0);
`ifdef VIDEO_WQ_STATUS_EN
        chk("rand_level", 68'(wq_level), 68'h0);
`endif
        vblank = 1'b0;
        wait_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
